// File: rtl/chip_bus_slave_requester.sv
// ---------------------------------------------------------------------------
// chip_bus_slave_requester
//
// Purpose:
//   Slave-side requester for the chip_bus protocol. It takes one read/write
//   command at a time from a local client. It raises interrupt_request with
//   the command address and waits for grant from the bus master. It then
//   runs one DATA_W-bit data phase that completes on ready, and finally
//   returns a single-cycle response. A timeout on either wait produces an
//   error response. TIMEOUT = 0 disables the timeout.
//
// Ports:
//   clock, resetN          : clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_accept   : client command handshake
//   cmd_write/addr/wdata   : command fields, latched on acceptance
//   rsp_valid/rdata/error  : one-cycle response (rdata is 0 on write/error)
//   busy                   : engine is not idle
//   interrupt_request      : bus request, held while waiting for grant
//   address                : bus address, non-zero only while requesting
//   grant, ready           : master grant and data-phase completion
//   data_o/data_oe         : write data and its drive enable
//   data_i                 : read data, sampled when ready is seen
// ---------------------------------------------------------------------------
module chip_bus_slave_requester #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              cmd_valid,
    output logic              cmd_accept,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              busy,
    output logic              interrupt_request,
    output logic [ADDR_W-1:0] address,
    input  logic              grant,
    input  logic              ready,
    output logic [DATA_W-1:0] data_o,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_i
);

    // A timer of at least one bit keeps the logic legal when TIMEOUT is 0.
    localparam int              TMR_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit              TMO_EN   = (TIMEOUT != 0);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              r_state;
    logic [TMR_W-1:0]    r_timer;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_irq;
    logic [ADDR_W-1:0]   r_address;
    logic [DATA_W-1:0]   r_data_o;
    logic                r_data_oe;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_error;

    logic                w_expired;
    logic                w_accept;

    // Handshake and status views of the FSM.
    assign w_accept   = (r_state == IDLE) && resetN;
    assign cmd_accept = w_accept;
    assign busy       = (r_state != IDLE);

    // The awaited signal gives up when the timer sits at TIMEOUT-1 and the
    // signal is still low. A high sample in that same cycle still wins.
    always_comb begin
        w_expired = 1'b0;
        if (TMO_EN && (r_timer == TMR_LAST)) begin
            w_expired = 1'b1;
        end else begin
            w_expired = 1'b0;
        end
    end

    // Main request/transfer/response FSM with all bus and response outputs registered.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_irq       <= 1'b0;
            r_address   <= '0;
            r_data_o    <= '0;
            r_data_oe   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid && w_accept) begin
                        r_write   <= cmd_write;
                        r_wdata   <= cmd_wdata;
                        r_address <= cmd_addr;
                        r_irq     <= 1'b1;
                        r_timer   <= '0;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    // ready has no meaning before grant, so it is not looked at here.
                    if (grant) begin
                        r_irq     <= 1'b0;
                        r_address <= '0;
                        r_timer   <= '0;
                        r_state   <= DATA;
                        if (r_write) begin
                            r_data_oe <= 1'b1;
                            r_data_o  <= r_wdata;
                        end
                    end else if (w_expired) begin
                        // The bus was never granted, so the data wire stays undriven.
                        r_irq       <= 1'b0;
                        r_address   <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= RESP;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                DATA: begin
                    if (ready) begin
                        r_data_oe   <= 1'b0;
                        r_data_o    <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b0;
                        r_rsp_rdata <= r_write ? '0 : data_i;
                        r_state     <= RESP;
                    end else if (w_expired) begin
                        r_data_oe   <= 1'b0;
                        r_data_o    <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= RESP;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                RESP: begin
                    // The response is fire-and-forget: one cycle, then back to idle.
                    r_rsp_valid <= 1'b0;
                    r_rsp_error <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_irq       <= 1'b0;
                    r_address   <= '0;
                    r_data_oe   <= 1'b0;
                    r_data_o    <= '0;
                    r_rsp_valid <= 1'b0;
                    r_rsp_error <= 1'b0;
                    r_rsp_rdata <= '0;
                end
            endcase
        end
    end

    assign interrupt_request = r_irq;
    assign address           = r_address;
    assign data_o            = r_data_o;
    assign data_oe           = r_data_oe;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_rdata         = r_rsp_rdata;
    assign rsp_error         = r_rsp_error;

endmodule
